id_operand_stage: RTL and testbench
===================================

ID_OPERAND_STAGE -- requirements
Module: id_operand_stage

Interface
REQ-001 Parameter DW, default 16, datapath width.
REQ-002 Parameter AW, default 4, register address width (16 registers).
REQ-003 The block SHALL have these ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- if_valid  in  1  if_instr holds a valid instruction.
- if_instr  in  DW  fetched instruction.
- id_stall  out  1  IF must hold if_instr (load-use or ex_hold).
- flush  in  1  kill the ID instruction and the ID/EX contents.
- ex_hold  in  1  downstream cannot accept; freeze the ID/EX register.
- re1, re2  out  1  regfile read enables.
- raddr1, raddr2  out  AW  regfile read addresses.
- rdata1, rdata2  in  DW  regfile read data, already WB-bypassed.
- ex_we, ex_is_load  in  1  EX-stage write enable / load flag.
- ex_waddr  in  AW;  ex_wdata  in  DW  EX-stage result.
- mem_we  in  1;  mem_waddr  in  AW;  mem_wdata  in  DW  MEM-stage result.
- idex_valid, idex_we, idex_mem_rd, idex_mem_wr  out  1  registered controls.
- idex_aluop  out  3;  idex_waddr  out  AW.
- idex_op1, idex_op2, idex_sdata  out  DW  registered operands and store data.
- stall_cnt  out  16  saturating count of load-use stall cycles.

Function
REQ-004 Decode fields: op=instr[15:12], rd=[11:8], rs=[7:4], rt=[3:0].
REQ-005 0x0 NOP; 0x1 ADD, 0x2 SUB, 0x3 AND, 0x4 OR: rd=rs op rt; port1=rs, port2=rt.
REQ-006 0x5 ADDI: rd=rd+sign-extended instr[7:0]; port1=rd, port2 unused.
REQ-007 0x6 LW: rd=mem[rs+zero-extended instr[3:0]]; port1=rs.
REQ-008 0x7 SW: mem[rs+zext instr[3:0]]=rd; port1=rs, port2=rd.
REQ-009 Opcodes 0x8-0xF SHALL be treated as NOP (no write, no memory access).
REQ-010 aluop encoding: 0 pass, 1 add, 2 sub, 3 and, 4 or; ADDI/LW/SW use add.
REQ-011 re1/re2/raddr1/raddr2 SHALL be combinational from if_instr, with reN=1 only when if_valid and the port is used; raddrN=0 when unused.
REQ-012 Forwarding per port: EX match (ex_we, ex_waddr==raddr, not ex_is_load) beats MEM match (mem_we, mem_waddr==raddr), which beats rdataN.
REQ-013 Load-use: if_valid, ex_we, ex_is_load, and ex_waddr equals a used source address -> id_stall=1, ID holds, one bubble (idex_valid=0, all enables 0) is loaded into ID/EX.
REQ-014 idex_op1 = forwarded port1; idex_op2 = immediate for ADDI/LW/SW, else forwarded port2; idex_sdata = forwarded port2 for SW, else 0.
REQ-015 NOP, illegal opcode, or if_valid=0 SHALL load a bubble.
REQ-016 ex_hold=1: all idex_* SHALL retain their values, id_stall=1, stall_cnt unchanged; a load-use bubble is not inserted that cycle.
REQ-017 flush=1 SHALL load a bubble regardless of ex_hold or load-use, and SHALL drive id_stall=0.
REQ-018 Latency: one cycle from a valid unstalled ID instruction to its idex_* outputs.
REQ-019 stall_cnt SHALL increment by one per cycle in which REQ-013 inserts a bubble, saturating at 0xFFFF.

Reset
REQ-020 When rst=1 at a clock edge, all idex_* outputs and stall_cnt SHALL become 0; rst overrides flush and ex_hold.
REQ-021 During rst=1, id_stall, re1 and re2 SHALL be 0.

Verification
REQ-022 ADD r3,r1,r2 with rdata1=0x0005, rdata2=0x0007, no forwarding -> next cycle idex_op1=0x0005, idex_op2=0x0007, aluop=1, waddr=3, we=1.
REQ-023 ex_we=1, ex_waddr=1, ex_wdata=0x1111 and mem_we=1, mem_waddr=1, mem_wdata=0x2222 -> idex_op1=0x1111; with ex_we=0 -> 0x2222.
REQ-024 LW r4 in EX (ex_is_load=1), ADD r5,r4,r0 in ID -> id_stall=1 for one cycle, one bubble issued, stall_cnt 0->1, ADD issues the following cycle.
REQ-025 ADDI r2,0xFF -> idex_op2=0xFFFF; SW r6,[r7+0xA] -> idex_op2=0x000A, idex_sdata=forwarded r6, mem_wr=1, we=0.
REQ-026 ex_hold=1 for 3 cycles -> idex_* stable; flush asserted with ex_hold -> bubble next cycle; rst mid-stall -> all outputs 0.

Source files
------------

// File: rtl/id_operand_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | id_operand_stage: decode, operand forwarding and ID/EX register       |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module id_operand_stage #(
  parameter int DW = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_valid,
  input  logic [DW-1:0] if_instr,
  output logic          id_stall,
  input  logic          flush,
  input  logic          ex_hold,
  output logic          re1,
  output logic          re2,
  output logic [AW-1:0] raddr1,
  output logic [AW-1:0] raddr2,
  input  logic [DW-1:0] rdata1,
  input  logic [DW-1:0] rdata2,
  input  logic          ex_we,
  input  logic          ex_is_load,
  input  logic [AW-1:0] ex_waddr,
  input  logic [DW-1:0] ex_wdata,
  input  logic          mem_we,
  input  logic [AW-1:0] mem_waddr,
  input  logic [DW-1:0] mem_wdata,
  output logic          idex_valid,
  output logic          idex_we,
  output logic          idex_mem_rd,
  output logic          idex_mem_wr,
  output logic [2:0]    idex_aluop,
  output logic [AW-1:0] idex_waddr,
  output logic [DW-1:0] idex_op1,
  output logic [DW-1:0] idex_op2,
  output logic [DW-1:0] idex_sdata,
  output logic [15:0]   stall_cnt
);

  localparam logic [3:0] c_OP_ADD  = 4'h1;
  localparam logic [3:0] c_OP_SUB  = 4'h2;
  localparam logic [3:0] c_OP_AND  = 4'h3;
  localparam logic [3:0] c_OP_OR   = 4'h4;
  localparam logic [3:0] c_OP_ADDI = 4'h5;
  localparam logic [3:0] c_OP_LW   = 4'h6;
  localparam logic [3:0] c_OP_SW   = 4'h7;

  localparam logic [2:0] c_ALU_PASS = 3'd0;
  localparam logic [2:0] c_ALU_ADD  = 3'd1;
  localparam logic [2:0] c_ALU_SUB  = 3'd2;
  localparam logic [2:0] c_ALU_AND  = 3'd3;
  localparam logic [2:0] c_ALU_OR   = 3'd4;

  logic [3:0]    w_op;
  logic [AW-1:0] w_rd, w_rs, w_rt;
  logic          w_is_alu, w_is_addi, w_is_lw, w_is_sw, w_legal;
  logic          w_use1, w_use2;
  logic [AW-1:0] w_src1, w_src2;
  logic          w_ex_hit1, w_ex_hit2, w_mem_hit1, w_mem_hit2;
  logic [DW-1:0] w_fwd1, w_fwd2, w_op2, w_imm8, w_imm4;
  logic          w_load_use, w_issue;
  logic [2:0]    w_aluop;

  logic          r_valid, r_we, r_mem_rd, r_mem_wr;
  logic [2:0]    r_aluop;
  logic [AW-1:0] r_waddr;
  logic [DW-1:0] r_op1, r_op2, r_sdata;
  logic [15:0]   r_stall_cnt;

  assign w_op = if_instr[15:12];
  assign w_rd = AW'(if_instr[11:8]);
  assign w_rs = AW'(if_instr[7:4]);
  assign w_rt = AW'(if_instr[3:0]);

  assign w_is_alu  = (w_op == c_OP_ADD) || (w_op == c_OP_SUB) ||
                     (w_op == c_OP_AND) || (w_op == c_OP_OR);
  assign w_is_addi = (w_op == c_OP_ADDI);
  assign w_is_lw   = (w_op == c_OP_LW);
  assign w_is_sw   = (w_op == c_OP_SW);
  assign w_legal   = w_is_alu | w_is_addi | w_is_lw | w_is_sw;

  // ADDI reads its own destination; SW reads rd as store data on port 2
  assign w_use1 = w_legal;
  assign w_use2 = w_is_alu | w_is_sw;
  assign w_src1 = w_is_addi ? w_rd : w_rs;
  assign w_src2 = w_is_sw ? w_rd : w_rt;

  assign raddr1 = w_use1 ? w_src1 : '0;
  assign raddr2 = w_use2 ? w_src2 : '0;
  assign re1    = ~rst & if_valid & w_use1;
  assign re2    = ~rst & if_valid & w_use2;

  // A load in EX has no data yet, so it never forwards; it stalls instead
  assign w_ex_hit1  = ex_we & ~ex_is_load & (ex_waddr == raddr1);
  assign w_ex_hit2  = ex_we & ~ex_is_load & (ex_waddr == raddr2);
  assign w_mem_hit1 = mem_we & (mem_waddr == raddr1);
  assign w_mem_hit2 = mem_we & (mem_waddr == raddr2);

  assign w_fwd1 = w_ex_hit1 ? ex_wdata : (w_mem_hit1 ? mem_wdata : rdata1);
  assign w_fwd2 = w_ex_hit2 ? ex_wdata : (w_mem_hit2 ? mem_wdata : rdata2);

  assign w_load_use = if_valid & ex_we & ex_is_load &
                      ((w_use1 & (ex_waddr == w_src1)) |
                       (w_use2 & (ex_waddr == w_src2)));

  assign id_stall = ~rst & ~flush & (ex_hold | w_load_use);
  assign w_issue  = if_valid & w_legal & ~w_load_use;

  assign w_imm8 = {{(DW-8){if_instr[7]}}, if_instr[7:0]};
  assign w_imm4 = {{(DW-4){1'b0}}, if_instr[3:0]};
  assign w_op2  = w_is_addi ? w_imm8 : ((w_is_lw | w_is_sw) ? w_imm4 : w_fwd2);

  always_comb begin
    w_aluop = c_ALU_PASS;
    case (w_op)
      c_OP_ADD, c_OP_ADDI, c_OP_LW, c_OP_SW: w_aluop = c_ALU_ADD;
      c_OP_SUB: w_aluop = c_ALU_SUB;
      c_OP_AND: w_aluop = c_ALU_AND;
      c_OP_OR:  w_aluop = c_ALU_OR;
      default:  w_aluop = c_ALU_PASS;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_valid  <= 1'b0;
      r_we     <= 1'b0;
      r_mem_rd <= 1'b0;
      r_mem_wr <= 1'b0;
      r_aluop  <= c_ALU_PASS;
      r_waddr  <= '0;
      r_op1    <= '0;
      r_op2    <= '0;
      r_sdata  <= '0;
      if (rst) r_stall_cnt <= 16'h0000;
    end else if (!ex_hold) begin
      if (w_load_use && r_stall_cnt != 16'hFFFF)
        r_stall_cnt <= r_stall_cnt + 16'h0001;
      r_valid  <= w_issue;
      r_we     <= w_issue & ~w_is_sw;
      r_mem_rd <= w_issue & w_is_lw;
      r_mem_wr <= w_issue & w_is_sw;
      r_aluop  <= w_issue ? w_aluop : c_ALU_PASS;
      r_waddr  <= (w_issue && !w_is_sw) ? w_rd : '0;
      r_op1    <= w_issue ? w_fwd1 : '0;
      r_op2    <= w_issue ? w_op2 : '0;
      r_sdata  <= (w_issue && w_is_sw) ? w_fwd2 : '0;
    end
  end

  assign idex_valid  = r_valid;
  assign idex_we     = r_we;
  assign idex_mem_rd = r_mem_rd;
  assign idex_mem_wr = r_mem_wr;
  assign idex_aluop  = r_aluop;
  assign idex_waddr  = r_waddr;
  assign idex_op1    = r_op1;
  assign idex_op2    = r_op2;
  assign idex_sdata  = r_sdata;
  assign stall_cnt   = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_id_operand_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_id_operand_stage: directed scoreboard bench for id_operand_stage   |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_id_operand_stage;

  typedef struct packed {
    logic        v, we, rd, wr;
    logic [2:0]  alu;
    logic [3:0]  wa;
    logic [15:0] op1, op2, sd, cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, if_valid, flush, ex_hold;
  logic [15:0] if_instr;
  logic        id_stall, re1, re2;
  logic [3:0]  raddr1, raddr2;
  logic [15:0] rdata1, rdata2;
  logic        ex_we, ex_is_load, mem_we;
  logic [3:0]  ex_waddr, mem_waddr;
  logic [15:0] ex_wdata, mem_wdata;
  logic        idex_valid, idex_we, idex_mem_rd, idex_mem_wr;
  logic [2:0]  idex_aluop;
  logic [3:0]  idex_waddr;
  logic [15:0] idex_op1, idex_op2, idex_sdata, stall_cnt;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];
  exp_t last;

  always #5 clk = ~clk;

  id_operand_stage #(.DW(16), .AW(4)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr),
    .id_stall(id_stall), .flush(flush), .ex_hold(ex_hold),
    .re1(re1), .re2(re2), .raddr1(raddr1), .raddr2(raddr2),
    .rdata1(rdata1), .rdata2(rdata2),
    .ex_we(ex_we), .ex_is_load(ex_is_load), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .idex_valid(idex_valid), .idex_we(idex_we), .idex_mem_rd(idex_mem_rd),
    .idex_mem_wr(idex_mem_wr), .idex_aluop(idex_aluop), .idex_waddr(idex_waddr),
    .idex_op1(idex_op1), .idex_op2(idex_op2), .idex_sdata(idex_sdata),
    .stall_cnt(stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic we, input logic rd, input logic wr,
                              input logic [2:0] alu, input logic [3:0] wa,
                              input logic [15:0] op1, input logic [15:0] op2,
                              input logic [15:0] sd, input logic [15:0] cnt);
    exp_t e;
    e = '{v: 1'b1, we: we, rd: rd, wr: wr, alu: alu, wa: wa,
          op1: op1, op2: op2, sd: sd, cnt: cnt};
    return e;
  endfunction

  function automatic exp_t bubble(input logic [15:0] cnt);
    exp_t e;
    e = '0;
    e.cnt = cnt;
    return e;
  endfunction

  task automatic push(input exp_t e);
    exp_q.push_back(e);
    last = e;
  endtask

  // Advance one clock and score the ID/EX register against the oldest expectation
  task automatic tick(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    n_checks++;
    assert (exp_q.size() > 0) else begin
      n_fail++;
      $error("FAIL %s.queue observed=empty expected=entry", tag);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, ".valid"}, idex_valid, e.v);
      chk({tag, ".we"},    idex_we,    e.we);
      chk({tag, ".mem_rd"}, idex_mem_rd, e.rd);
      chk({tag, ".mem_wr"}, idex_mem_wr, e.wr);
      chk({tag, ".aluop"}, idex_aluop, e.alu);
      chk({tag, ".waddr"}, idex_waddr, e.wa);
      chk({tag, ".op1"},   idex_op1,   e.op1);
      chk({tag, ".op2"},   idex_op2,   e.op2);
      chk({tag, ".sdata"}, idex_sdata, e.sd);
      chk({tag, ".stall_cnt"}, stall_cnt, e.cnt);
    end
  endtask

  task automatic clr();
    rst = 1'b0; flush = 1'b0; ex_hold = 1'b0;
    if_valid = 1'b0; if_instr = 16'h0000;
    rdata1 = 16'h0000; rdata2 = 16'h0000;
    ex_we = 1'b0; ex_is_load = 1'b0; ex_waddr = 4'h0; ex_wdata = 16'h0000;
    mem_we = 1'b0; mem_waddr = 4'h0; mem_wdata = 16'h0000;
  endtask

  initial begin
    clr();
    // Reset wins over flush, hold and a pending load-use
    rst = 1'b1; flush = 1'b1; ex_hold = 1'b1; if_valid = 1'b1; if_instr = 16'h1312;
    ex_we = 1'b1; ex_is_load = 1'b1; ex_waddr = 4'h1;
    #1;
    chk("rst.id_stall", id_stall, 1'b0);
    chk("rst.re1", re1, 1'b0);
    chk("rst.re2", re2, 1'b0);
    push(bubble(16'h0)); tick("rst0");
    push(bubble(16'h0)); tick("rst1");

    // ADD r3,r1,r2 from the register file
    clr(); if_valid = 1'b1; if_instr = 16'h1312; rdata1 = 16'h0005; rdata2 = 16'h0007;
    #1;
    chk("add.re1", re1, 1'b1);
    chk("add.raddr1", raddr1, 4'h1);
    chk("add.re2", re2, 1'b1);
    chk("add.raddr2", raddr2, 4'h2);
    chk("add.id_stall", id_stall, 1'b0);
    push(mk(1, 0, 0, 3'd1, 4'h3, 16'h0005, 16'h0007, 16'h0, 16'h0)); tick("add");

    // EX beats MEM, MEM beats the register file
    ex_we = 1'b1; ex_waddr = 4'h1; ex_wdata = 16'h1111;
    mem_we = 1'b1; mem_waddr = 4'h1; mem_wdata = 16'h2222;
    push(mk(1, 0, 0, 3'd1, 4'h3, 16'h1111, 16'h0007, 16'h0, 16'h0)); tick("fwd_ex");
    ex_we = 1'b0;
    push(mk(1, 0, 0, 3'd1, 4'h3, 16'h2222, 16'h0007, 16'h0, 16'h0)); tick("fwd_mem");

    clr(); if_valid = 1'b1; if_instr = 16'h2412; rdata1 = 16'h0009; rdata2 = 16'h0003;
    push(mk(1, 0, 0, 3'd2, 4'h4, 16'h0009, 16'h0003, 16'h0, 16'h0)); tick("sub");
    if_instr = 16'h3612;
    push(mk(1, 0, 0, 3'd3, 4'h6, 16'h0009, 16'h0003, 16'h0, 16'h0)); tick("and");
    if_instr = 16'h4512; mem_we = 1'b1; mem_waddr = 4'h2; mem_wdata = 16'hABCD;
    push(mk(1, 0, 0, 3'd4, 4'h5, 16'h0009, 16'hABCD, 16'h0, 16'h0)); tick("or_fwd2");

    // ADDI r2,0xFF reads rd on port 1 and sign-extends
    clr(); if_valid = 1'b1; if_instr = 16'h52FF; rdata1 = 16'h0010;
    #1;
    chk("addi.raddr1", raddr1, 4'h2);
    chk("addi.re2", re2, 1'b0);
    chk("addi.raddr2", raddr2, 4'h0);
    push(mk(1, 0, 0, 3'd1, 4'h2, 16'h0010, 16'hFFFF, 16'h0, 16'h0)); tick("addi");

    // SW r6,[r7+0xA] with r6 forwarded from MEM
    clr(); if_valid = 1'b1; if_instr = 16'h767A; rdata1 = 16'h0100; rdata2 = 16'h0666;
    mem_we = 1'b1; mem_waddr = 4'h6; mem_wdata = 16'h6060;
    #1;
    chk("sw.raddr1", raddr1, 4'h7);
    chk("sw.raddr2", raddr2, 4'h6);
    push(mk(0, 0, 1, 3'd1, 4'h0, 16'h0100, 16'h000A, 16'h6060, 16'h0)); tick("sw");

    clr(); if_valid = 1'b1; if_instr = 16'h6835; rdata1 = 16'h0030;
    push(mk(1, 1, 0, 3'd1, 4'h8, 16'h0030, 16'h0005, 16'h0, 16'h0)); tick("lw");

    // Illegal, NOP and invalid instructions all become bubbles
    if_instr = 16'h9123;
    #1;
    chk("ill.re1", re1, 1'b0);
    chk("ill.raddr1", raddr1, 4'h0);
    push(bubble(16'h0)); tick("illegal");
    if_instr = 16'h0000;
    push(bubble(16'h0)); tick("nop");
    if_valid = 1'b0; if_instr = 16'h1312;
    #1;
    chk("inv.re1", re1, 1'b0);
    push(bubble(16'h0)); tick("invalid");

    // Load-use: LW r4 in EX, ADD r5,r4,r0 in ID
    clr(); if_valid = 1'b1; if_instr = 16'h1540;
    ex_we = 1'b1; ex_is_load = 1'b1; ex_waddr = 4'h4; ex_wdata = 16'hDEAD;
    #1;
    chk("lu.id_stall", id_stall, 1'b1);
    push(bubble(16'h1)); tick("lu_bubble");
    clr(); if_valid = 1'b1; if_instr = 16'h1540;
    mem_we = 1'b1; mem_waddr = 4'h4; mem_wdata = 16'h4444;
    #1;
    chk("lu.release", id_stall, 1'b0);
    push(mk(1, 0, 0, 3'd1, 4'h5, 16'h4444, 16'h0000, 16'h0, 16'h1)); tick("lu_issue");

    // ex_hold freezes ID/EX and suppresses the load-use bubble
    clr(); ex_hold = 1'b1; if_valid = 1'b1; if_instr = 16'h1312;
    rdata1 = 16'h000A; rdata2 = 16'h000B;
    ex_we = 1'b1; ex_is_load = 1'b1; ex_waddr = 4'h1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold.id_stall", id_stall, 1'b1);
      push(last); tick("hold");
    end
    ex_hold = 1'b0; ex_we = 1'b0; ex_is_load = 1'b0;
    push(mk(1, 0, 0, 3'd1, 4'h3, 16'h000A, 16'h000B, 16'h0, 16'h1)); tick("hold_release");

    // flush beats ex_hold and releases IF
    ex_hold = 1'b1; flush = 1'b1;
    #1;
    chk("flush.id_stall", id_stall, 1'b0);
    push(bubble(16'h1)); tick("flush");

    // Second load-use on port 2, then a valid issue, then reset mid-stall
    clr(); if_valid = 1'b1; if_instr = 16'h1312; ex_we = 1'b1; ex_is_load = 1'b1; ex_waddr = 4'h2;
    push(bubble(16'h2)); tick("lu2");
    clr(); if_valid = 1'b1; if_instr = 16'h1312; rdata1 = 16'h0001; rdata2 = 16'h0002;
    push(mk(1, 0, 0, 3'd1, 4'h3, 16'h0001, 16'h0002, 16'h0, 16'h2)); tick("pre_rst");
    ex_hold = 1'b1; ex_we = 1'b1; ex_is_load = 1'b1; ex_waddr = 4'h1; rst = 1'b1;
    #1;
    chk("rst_mid.id_stall", id_stall, 1'b0);
    chk("rst_mid.re1", re1, 1'b0);
    push(bubble(16'h0)); tick("rst_mid");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
